trav_stack: RTL and testbench
=============================

Name: trav_stack

Overview:
- Per-ray short stack for kd-tree traversal deferred nodes.
- Consumes the "push far child" results of the traversal math stage (cases 2/3: node, t_min = t_mid, t_max = t_max).
- Serves pops back to the traversal scheduler when a ray finishes a leaf without a hit.
- On overflow it keeps the newest DEPTH entries. A pop of an empty, overflowed stack returns a restart indication so the ray re-traverses from the root.

Parameters:
- NUM_RAYS, 8, number of rays in flight; one independent stack per ray ID.
- DEPTH, 4, entries per ray stack; must be a power of 2 and at least 2.
- NODE_W, 16, width of a kd-tree node address.
- RID_W, $clog2(NUM_RAYS), ray ID width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- clear_valid  in  1  reset the stack of clear_ray_id (new ray issued).
- clear_ray_id  in  RID_W  ray ID to clear.
- push_valid  in  1  push request.
- push_ready  out  1  push accepted when push_valid && push_ready.
- push_ray_id  in  RID_W  target ray.
- push_node  in  NODE_W  deferred node address.
- push_t_min  in  32  float_t t_min of deferred segment.
- push_t_max  in  32  float_t t_max of deferred segment.
- pop_valid  in  1  pop request.
- pop_ready  out  1  pop accepted when pop_valid && pop_ready.
- pop_ray_id  in  RID_W  ray to pop.
- resp_valid  out  1  pop response valid.
- resp_ready  in  1  downstream accepts the response.
- resp_ray_id  out  RID_W  echoed ray ID.
- resp_hit  out  1  1 = entry returned; 0 = stack empty.
- resp_restart  out  1  empty and an overflow occurred since the last clear/empty-pop.
- resp_node  out  NODE_W  popped node; 0 when resp_hit=0.
- resp_t_min  out  32  popped t_min; 0 when resp_hit=0.
- resp_t_max  out  32  popped t_max; 0 when resp_hit=0.

Behaviour:
- Each ray has: circular entry array[DEPTH], top pointer ptr (log2 DEPTH bits), count 0..DEPTH, ovf flag.
- Reset (rst low, async): all ptr/count/ovf = 0. resp_valid, resp_hit, resp_restart = 0; resp data = 0. Entry array contents are don't-care.
- Priority per ray per cycle: clear > pop > push.
  - clear_valid blocks push_ready if push_ray_id==clear_ray_id, and pop_ready if pop_ray_id==clear_ray_id.
  - An accepted pop to the same ray as push_ray_id forces push_ready=0.
  - Operations on different rays in the same cycle all proceed.
- Clear: ptr=0, count=0, ovf=0 next cycle.
- Push, count<DEPTH: write entry at ptr; ptr=ptr+1 (wraps mod DEPTH); count+1.
- Push, count==DEPTH (full): overwrite the oldest entry at ptr; ptr+1; count unchanged; ovf=1.
- pop_ready = (!resp_valid || resp_ready) && no conflicting clear.
- Pop, count>0: response carries entry[ptr-1]; ptr-1 (wraps); count-1; resp_hit=1; resp_restart=0.
- Pop, count==0: resp_hit=0; resp_restart=ovf; ovf cleared; data fields 0.
- Response latency is exactly 1 cycle after acceptance (registered).
  - resp_valid is held with stable data while resp_ready=0.
  - resp_valid drops the cycle after a handshake unless a new pop was accepted in that same cycle (back-to-back allowed, full throughput).
- Stack state updates at acceptance, so a push in the cycle after a pop sees the decremented state.
- Ray IDs at or above NUM_RAYS are undefined; the bench must not drive them.
- The block does no float arithmetic; t values pass through bit-exact.

Test Plan:
- Reset, then pop ray 3 -> next cycle resp_valid=1, resp_ray_id=3, hit=0, restart=0.
- Push ray 1 nodes 0x10 (t_min 0x3F800000, t_max 0x40000000), then 0x20 (0x40000000, 0x40400000); pop twice -> node 0x20 then 0x10 with exact t values; third pop gives hit=0.
- DEPTH=4: push nodes 1..6 to ray 2; pop x5 -> 6, 5, 4, 3 with hit=1, then hit=0, restart=1; a sixth pop gives restart=0.
- Same-cycle push and pop on ray 5 (count=1) -> push_ready=0, pop returns the old top; push succeeds next cycle. Push ray 0 with pop ray 5 in the same cycle -> both accepted.
- Hold resp_ready=0 for 3 cycles with a response pending -> resp fields stable, pop_ready=0. Release -> next pop is accepted in the same cycle as the handshake.
- Clear ray 4 concurrently with push to ray 4 -> push_ready=0; later pop gives hit=0, restart=0. Assert rst mid-stream -> outputs go to 0 immediately.

Source files
------------

// File: rtl/trav_stack.sv
// trav_stack: per-ray circular short stack of deferred kd-tree nodes with overflow-restart signalling
module trav_stack #(
    parameter int NUM_RAYS = 8,
    parameter int DEPTH    = 4,
    parameter int NODE_W   = 16,
    parameter int RID_W    = $clog2(NUM_RAYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_valid,
    input  logic [RID_W-1:0]  clear_ray_id,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [RID_W-1:0]  push_ray_id,
    input  logic [NODE_W-1:0] push_node,
    input  logic [31:0]       push_t_min,
    input  logic [31:0]       push_t_max,
    input  logic              pop_valid,
    output logic              pop_ready,
    input  logic [RID_W-1:0]  pop_ray_id,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RID_W-1:0]  resp_ray_id,
    output logic              resp_hit,
    output logic              resp_restart,
    output logic [NODE_W-1:0] resp_node,
    output logic [31:0]       resp_t_min,
    output logic [31:0]       resp_t_max
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [NODE_W-1:0]   node_mem [NUM_RAYS][DEPTH];
    logic [31:0]         tmin_mem [NUM_RAYS][DEPTH];
    logic [31:0]         tmax_mem [NUM_RAYS][DEPTH];
    logic [PW-1:0]       ptr [NUM_RAYS];
    logic [CW-1:0]       cnt [NUM_RAYS];
    logic [NUM_RAYS-1:0] ovf;
    logic                pop_fire, push_fire, pop_hit;
    logic [PW-1:0]       top_idx;
    assign pop_ready  = (!resp_valid || resp_ready) && !(clear_valid && clear_ray_id == pop_ray_id);
    assign pop_fire   = pop_valid && pop_ready;
    assign push_ready = !(clear_valid && clear_ray_id == push_ray_id) && !(pop_fire && pop_ray_id == push_ray_id);
    assign push_fire  = push_valid && push_ready;
    assign top_idx    = ptr[pop_ray_id] - PW'(1);
    assign pop_hit    = cnt[pop_ray_id] != '0;
    // Entry storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            node_mem[push_ray_id][ptr[push_ray_id]] <= push_node;
            tmin_mem[push_ray_id][ptr[push_ray_id]] <= push_t_min;
            tmax_mem[push_ray_id][ptr[push_ray_id]] <= push_t_max;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_RAYS; r++) begin
                ptr[r] <= '0;
                cnt[r] <= '0;
            end
            ovf          <= '0;
            resp_valid   <= 1'b0;
            resp_ray_id  <= '0;
            resp_hit     <= 1'b0;
            resp_restart <= 1'b0;
            resp_node    <= '0;
            resp_t_min   <= '0;
            resp_t_max   <= '0;
        end else begin
            for (int r = 0; r < NUM_RAYS; r++) begin
                if (clear_valid && clear_ray_id == RID_W'(r)) begin
                    ptr[r] <= '0;
                    cnt[r] <= '0;
                    ovf[r] <= 1'b0;
                end else if (pop_fire && pop_ray_id == RID_W'(r)) begin
                    if (cnt[r] != '0) begin
                        ptr[r] <= ptr[r] - PW'(1);
                        cnt[r] <= cnt[r] - CW'(1);
                    end else begin
                        ovf[r] <= 1'b0;
                    end
                end else if (push_fire && push_ray_id == RID_W'(r)) begin
                    // When full, the write lands on the oldest slot, so only ptr moves.
                    ptr[r] <= ptr[r] + PW'(1);
                    if (cnt[r] == CW'(DEPTH))
                        ovf[r] <= 1'b1;
                    else
                        cnt[r] <= cnt[r] + CW'(1);
                end
            end
            if (pop_fire) begin
                resp_valid   <= 1'b1;
                resp_ray_id  <= pop_ray_id;
                resp_hit     <= pop_hit;
                resp_restart <= !pop_hit && ovf[pop_ray_id];
                resp_node    <= pop_hit ? node_mem[pop_ray_id][top_idx] : '0;
                resp_t_min   <= pop_hit ? tmin_mem[pop_ray_id][top_idx] : '0;
                resp_t_max   <= pop_hit ? tmax_mem[pop_ray_id][top_idx] : '0;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_trav_stack.sv
// tb_trav_stack: directed self-checking bench for trav_stack
module tb_trav_stack;
    logic        clk = 1'b0;
    logic        rst;
    logic        clear_valid;
    logic [2:0]  clear_ray_id;
    logic        push_valid;
    logic        push_ready;
    logic [2:0]  push_ray_id;
    logic [15:0] push_node;
    logic [31:0] push_t_min;
    logic [31:0] push_t_max;
    logic        pop_valid;
    logic        pop_ready;
    logic [2:0]  pop_ray_id;
    logic        resp_valid;
    logic        resp_ready;
    logic [2:0]  resp_ray_id;
    logic        resp_hit;
    logic        resp_restart;
    logic [15:0] resp_node;
    logic [31:0] resp_t_min;
    logic [31:0] resp_t_max;
    int checks = 0;
    int errors = 0;
    trav_stack dut (
        .clk(clk), .rst(rst),
        .clear_valid(clear_valid), .clear_ray_id(clear_ray_id),
        .push_valid(push_valid), .push_ready(push_ready), .push_ray_id(push_ray_id),
        .push_node(push_node), .push_t_min(push_t_min), .push_t_max(push_t_max),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_ray_id(pop_ray_id),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ray_id(resp_ray_id),
        .resp_hit(resp_hit), .resp_restart(resp_restart), .resp_node(resp_node),
        .resp_t_min(resp_t_min), .resp_t_max(resp_t_max)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [2:0] id, input logic [15:0] n, input logic [31:0] lo, input logic [31:0] hi);
        push_valid = 1'b1; push_ray_id = id; push_node = n; push_t_min = lo; push_t_max = hi;
        step();
        push_valid = 1'b0;
    endtask
    task automatic pop(input logic [2:0] id);
        pop_valid = 1'b1; pop_ray_id = id;
        step();
        pop_valid = 1'b0;
    endtask
    task automatic chk_resp(input string tag, input logic [2:0] id, input logic hit, input logic rs, input logic [15:0] n,
                            input logic [31:0] lo, input logic [31:0] hi);
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_ray"}, 32'(resp_ray_id), 32'(id));
        chk({tag, "_hit"}, 32'(resp_hit), 32'(hit));
        chk({tag, "_restart"}, 32'(resp_restart), 32'(rs));
        chk({tag, "_node"}, 32'(resp_node), 32'(n));
        chk({tag, "_tmin"}, resp_t_min, lo);
        chk({tag, "_tmax"}, resp_t_max, hi);
    endtask
    initial begin
        rst = 1'b0; clear_valid = 0; clear_ray_id = 0; push_valid = 0; push_ray_id = 0;
        push_node = 0; push_t_min = 0; push_t_max = 0; pop_valid = 0; pop_ray_id = 0; resp_ready = 1'b1;
        #1;
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_hit", 32'(resp_hit), 32'd0);
        chk("rst_node", 32'(resp_node), 32'd0);
        step(); step();
        rst = 1'b1;
        step();
        pop_valid = 1'b1; pop_ray_id = 3'd3;
        #1 chk("empty_pop_ready", 32'(pop_ready), 32'd1);
        step();
        pop_valid = 1'b0;
        chk_resp("empty3", 3'd3, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
        step();
        chk("drop_valid", 32'(resp_valid), 32'd0);
        push(3'd1, 16'h10, 32'h3F800000, 32'h40000000);
        push(3'd1, 16'h20, 32'h40000000, 32'h40400000);
        pop_valid = 1'b1; pop_ray_id = 3'd1;
        step();
        chk_resp("r1a", 3'd1, 1'b1, 1'b0, 16'h20, 32'h40000000, 32'h40400000);
        step();
        chk_resp("r1b", 3'd1, 1'b1, 1'b0, 16'h10, 32'h3F800000, 32'h40000000);
        step();
        pop_valid = 1'b0;
        chk_resp("r1c", 3'd1, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
        for (int i = 1; i <= 6; i++) push(3'd2, 16'(i), 32'(i), 32'(i + 100));
        for (int i = 6; i >= 3; i--) begin
            pop(3'd2);
            chk_resp("ovf_hit", 3'd2, 1'b1, 1'b0, 16'(i), 32'(i), 32'(i + 100));
        end
        pop(3'd2);
        chk_resp("ovf_restart", 3'd2, 1'b0, 1'b1, 16'h0, 32'h0, 32'h0);
        pop(3'd2);
        chk_resp("ovf_cleared", 3'd2, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
        push(3'd5, 16'h55, 32'h1, 32'h2);
        push_valid = 1'b1; push_ray_id = 3'd5; push_node = 16'h56; push_t_min = 32'h3; push_t_max = 32'h4;
        pop_valid = 1'b1; pop_ray_id = 3'd5;
        #1;
        chk("conf_push_ready", 32'(push_ready), 32'd0);
        chk("conf_pop_ready", 32'(pop_ready), 32'd1);
        step();
        pop_valid = 1'b0;
        chk_resp("conf_pop", 3'd5, 1'b1, 1'b0, 16'h55, 32'h1, 32'h2);
        #1 chk("retry_push_ready", 32'(push_ready), 32'd1);
        step();
        push_valid = 1'b0;
        pop(3'd5);
        chk_resp("retry_pop", 3'd5, 1'b1, 1'b0, 16'h56, 32'h3, 32'h4);
        push_valid = 1'b1; push_ray_id = 3'd0; push_node = 16'h77; push_t_min = 32'h5; push_t_max = 32'h6;
        pop_valid = 1'b1; pop_ray_id = 3'd5;
        #1;
        chk("par_push_ready", 32'(push_ready), 32'd1);
        chk("par_pop_ready", 32'(pop_ready), 32'd1);
        step();
        push_valid = 1'b0; pop_valid = 1'b0;
        chk_resp("par_pop", 3'd5, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
        pop(3'd0);
        chk_resp("par_push", 3'd0, 1'b1, 1'b0, 16'h77, 32'h5, 32'h6);
        push(3'd6, 16'h61, 32'h11, 32'h12);
        push(3'd6, 16'h62, 32'h21, 32'h22);
        resp_ready = 1'b0;
        pop(3'd6);
        pop_valid = 1'b1; pop_ray_id = 3'd6;
        for (int i = 0; i < 3; i++) begin
            chk("hold_pop_ready", 32'(pop_ready), 32'd0);
            chk_resp("hold", 3'd6, 1'b1, 1'b0, 16'h62, 32'h21, 32'h22);
            step();
        end
        resp_ready = 1'b1;
        #1 chk("release_pop_ready", 32'(pop_ready), 32'd1);
        step();
        pop_valid = 1'b0;
        chk_resp("b2b", 3'd6, 1'b1, 1'b0, 16'h61, 32'h11, 32'h12);
        step();
        chk("b2b_drop", 32'(resp_valid), 32'd0);
        push(3'd4, 16'h44, 32'h7, 32'h8);
        clear_valid = 1'b1; clear_ray_id = 3'd4;
        push_valid = 1'b1; push_ray_id = 3'd4; push_node = 16'h45;
        pop_valid = 1'b1; pop_ray_id = 3'd4;
        #1;
        chk("clr_push_ready", 32'(push_ready), 32'd0);
        chk("clr_pop_ready", 32'(pop_ready), 32'd0);
        step();
        clear_valid = 1'b0; push_valid = 1'b0; pop_valid = 1'b0;
        chk("clr_no_resp", 32'(resp_valid), 32'd0);
        pop(3'd4);
        chk_resp("clr_pop", 3'd4, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
        push(3'd3, 16'h33, 32'h9, 32'hA);
        push(3'd7, 16'hABCD, 32'hB, 32'hC);
        resp_ready = 1'b0;
        pop(3'd7);
        chk_resp("pre_rst", 3'd7, 1'b1, 1'b0, 16'hABCD, 32'hB, 32'hC);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_hit", 32'(resp_hit), 32'd0);
        chk("mid_rst_ray", 32'(resp_ray_id), 32'd0);
        chk("mid_rst_node", 32'(resp_node), 32'd0);
        chk("mid_rst_tmin", resp_t_min, 32'd0);
        step();
        rst = 1'b1; resp_ready = 1'b1;
        step();
        pop(3'd3);
        chk_resp("post_rst", 3'd3, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
